raster_dispatch_ctrl: RTL and testbench
=======================================

Name: raster_dispatch_ctrl

Overview:
- Sequences the triangle gatherer and the rasterizer core. Owns the gatherer's `dequeue` strobe, so one assembled triangle (3 vertices, 3 colours) moves to the rasterizer only when that core is free.
- Keeps the gatherer outputs stable while a triangle is rasterized, counts triangles per frame, turns the gatherer's end-of-stream flush into a frame-done pulse, and flags stalls on the input.

Parameters:
- CNT_W, 16, width of the triangle counters.
- STALL_W, 10, width of the stall timer.
- STALL_LIMIT, 1023, cycles in REQ before `stall` asserts; must be less than 2^STALL_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  dispatch enable; when low, finish the current triangle, then idle.
- tri_ready  in  1  gatherer one-cycle pulse: triangle outputs are valid and stable.
- tri_flush  in  1  gatherer one-cycle pulse: end-of-stream marker consumed.
- dequeue  out  1  request to the gatherer to release the next triangle.
- rast_start  out  1  one-cycle pulse: rasterizer samples the gatherer triangle outputs.
- rast_busy  in  1  rasterizer busy level.
- rast_done  in  1  rasterizer one-cycle completion pulse.
- frame_done  out  1  one-cycle pulse at end of frame.
- tri_count  out  CNT_W  triangles completed in the current frame.
- frame_tri_count  out  CNT_W  triangles in the last completed frame.
- stall  out  1  sticky stall flag; cleared by the next tri_ready.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset: all outputs are registered.
  - On rst_n low, immediately: dequeue=0, rast_start=0, frame_done=0, tri_count=0, frame_tri_count=0, stall=0, state=IDLE, flush_pend=0, stall timer=0.
  - Reset asserted mid-operation abandons any in-flight triangle; no frame_done is produced.
- States: IDLE=0, REQ=1, START=2, RUN=3, DRAIN=4.
- IDLE transitions, in priority order:
  - tri_ready → START. This covers a late ready caused by dequeue dropping the same cycle the gatherer accepted it.
  - Else flush_pend → DRAIN.
  - Else en → REQ.
- REQ: dequeue=1, held as a level.
  - tri_ready → START; dequeue is 0 from the next cycle.
  - Else tri_flush → DRAIN, setting flush_pend.
  - Else !en → IDLE.
  - Stall timer increments every REQ cycle and saturates. When it reaches STALL_LIMIT, stall=1.
  - Timer clears on leaving REQ. stall clears only on tri_ready.
- START: rast_start=1 for exactly one cycle → RUN.
- RUN: dequeue stays 0, so gatherer outputs cannot change.
  - On rast_done, tri_count+1, saturating at all-ones.
  - Then flush_pend → DRAIN; else en → REQ; else IDLE.
- DRAIN: wait for rast_busy=0, then:
  - frame_done=1 for one cycle.
  - frame_tri_count ← tri_count (the value including any increment that same cycle).
  - tri_count ← 0, flush_pend ← 0.
  - → IDLE.
- flush_pend: set by tri_flush sampled in any state except DRAIN.
- Simultaneous events:
  - tri_ready and tri_flush in the same cycle: ready wins and the flush is recorded.
  - rast_done and tri_flush in RUN: count increments, then DRAIN.
- Latency: tri_ready at edge t gives rast_start=1 and dequeue=0 in cycle t+1. Minimum per-triangle overhead is 3 cycles plus rasterizer time.
- An empty frame (flush with no triangles) produces frame_done with frame_tri_count=0.
- rast_done outside RUN is ignored.

Decomposition:
- Package `raster_pkg`:
  - state enum (IDLE..DRAIN, 3-bit);
  - default CNT_W/STALL_W/STALL_LIMIT constants;
  - the all-ones 96-bit flush marker constant shared with the gatherer.
- One sub-module, `sat_counter`: parameterized width, with inc, clr and async rst_n, saturating at max. It is instantiated for tri_count and the stall timer.

Test Plan:
- Three triangles, en=1, tri_ready 4 cycles after each dequeue, rasterizer 10 cycles:
  - three rast_start pulses, each one cycle after tri_ready;
  - dequeue never high while rast_busy=1;
  - tri_count=3.
- After 3 triangles, pulse tri_flush in REQ → dequeue drops next cycle, frame_done once, frame_tri_count=3, tri_count=0.
- Hold tri_ready low with en=1 → stall=1 exactly STALL_LIMIT cycles after entering REQ; next tri_ready clears it.
- Drop en in the same cycle tri_ready is generated:
  - controller passes IDLE, then reaches START;
  - one rast_start pulse, no lost triangle.
- tri_flush and rast_done together in RUN → tri_count increments, then frame_done with the incremented frame_tri_count.
- Assert rst_n low during RUN → all outputs 0 asynchronously; after release, IDLE, and no frame_done.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and default sizes for the raster dispatch controller.
// The flush marker constant is common with the triangle gatherer.
package raster_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } rd_state_e;

    localparam int RD_CNT_W       = 16;
    localparam int RD_STALL_W     = 10;
    localparam int RD_STALL_LIMIT = 1023;

    localparam logic [95:0] TRI_FLUSH_MARKER = {96{1'b1}};

    function automatic logic is_flush_marker(input logic [95:0] v);
        return v == TRI_FLUSH_MARKER;
    endfunction

endpackage

// File: rtl/raster_dispatch_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at its maximum value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/raster_dispatch_ctrl.sv
// Hands one gathered triangle at a time to the rasterizer, counts
// triangles per frame and turns the gatherer flush into frame_done.
module raster_dispatch_ctrl
    import raster_pkg::*;
#(
    parameter int CNT_W       = RD_CNT_W,
    parameter int STALL_W     = RD_STALL_W,
    parameter int STALL_LIMIT = RD_STALL_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tri_ready,
    input  logic             tri_flush,
    output logic             dequeue,
    output logic             rast_start,
    input  logic             rast_busy,
    input  logic             rast_done,
    output logic             frame_done,
    output logic [CNT_W-1:0] tri_count,
    output logic [CNT_W-1:0] frame_tri_count,
    output logic             stall,
    output logic [2:0]       state_dbg
);

    rd_state_e          r_state;
    rd_state_e          w_next;
    logic               r_dequeue;
    logic               r_rast_start;
    logic               r_frame_done;
    logic               r_stall;
    logic               r_flush_pend;
    logic [CNT_W-1:0]   r_frame_tri_count;
    logic [CNT_W-1:0]   w_tri_count;
    logic [STALL_W-1:0] w_stall_t;
    logic               w_in_req;
    logic               w_cnt_inc;
    logic               w_drain_fire;
    logic               w_stall_hit;

    assign w_in_req     = (r_state == S_REQ);
    assign w_cnt_inc    = (r_state == S_RUN) && rast_done;
    assign w_drain_fire = (r_state == S_DRAIN) && !rast_busy;
    // Compare against LIMIT-1 so stall rises on the edge the timer hits LIMIT
    assign w_stall_hit  = w_in_req &&
                          (w_stall_t >= STALL_W'(STALL_LIMIT - 1));

    sat_counter #(.W(CNT_W)) u_tri_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_cnt_inc),
        .i_clr (w_drain_fire),
        .o_q   (w_tri_count)
    );

    sat_counter #(.W(STALL_W)) u_stall_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_in_req),
        .i_clr (!w_in_req),
        .o_q   (w_stall_t)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (tri_ready)         w_next = S_START;
                else if (r_flush_pend) w_next = S_DRAIN;
                else if (en)           w_next = S_REQ;
            end
            S_REQ: begin
                if (tri_ready)      w_next = S_START;
                else if (tri_flush) w_next = S_DRAIN;
                else if (!en)       w_next = S_IDLE;
            end
            S_START: w_next = S_RUN;
            S_RUN: begin
                if (rast_done) begin
                    if (r_flush_pend || tri_flush) w_next = S_DRAIN;
                    else if (en)                   w_next = S_REQ;
                    else                           w_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!rast_busy) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_dequeue         <= 1'b0;
            r_rast_start      <= 1'b0;
            r_frame_done      <= 1'b0;
            r_stall           <= 1'b0;
            r_flush_pend      <= 1'b0;
            r_frame_tri_count <= '0;
        end else begin
            r_state      <= w_next;
            r_dequeue    <= (w_next == S_REQ);
            r_rast_start <= (w_next == S_START);
            r_frame_done <= w_drain_fire;
            if (w_drain_fire) begin
                r_frame_tri_count <= w_tri_count;
            end
            if (w_drain_fire) begin
                r_flush_pend <= 1'b0;
            end else if (tri_flush && (r_state != S_DRAIN)) begin
                r_flush_pend <= 1'b1;
            end
            if (tri_ready) begin
                r_stall <= 1'b0;
            end else if (w_stall_hit) begin
                r_stall <= 1'b1;
            end
        end
    end

    assign dequeue         = r_dequeue;
    assign rast_start      = r_rast_start;
    assign frame_done      = r_frame_done;
    assign tri_count       = w_tri_count;
    assign frame_tri_count = r_frame_tri_count;
    assign stall           = r_stall;
    assign state_dbg       = r_state;

endmodule

// File: tb/tb_raster_dispatch_ctrl.sv
// Scoreboard bench: gatherer and rasterizer models around the controller.
module tb_raster_dispatch_ctrl;

    localparam int CNT_W    = 16;
    localparam int STALL_W  = 10;
    localparam int LIMIT    = 20;
    localparam int RAST_CYC = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             tri_ready;
    logic             tri_flush;
    logic             dequeue;
    logic             rast_start;
    logic             rast_busy;
    logic             rast_done;
    logic             frame_done;
    logic [CNT_W-1:0] tri_count;
    logic [CNT_W-1:0] frame_tri_count;
    logic             stall;
    logic [2:0]       state_dbg;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sb_q[$];
    int          fq[$];
    int          tri_id   = 0;
    logic [31:0] tri_data = '0;
    int          n_starts = 0;
    int          n_frames = 0;
    int          deq_busy = 0;
    int          r_rcnt   = 0;

    raster_dispatch_ctrl #(
        .CNT_W       (CNT_W),
        .STALL_W     (STALL_W),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .tri_ready       (tri_ready),
        .tri_flush       (tri_flush),
        .dequeue         (dequeue),
        .rast_start      (rast_start),
        .rast_busy       (rast_busy),
        .rast_done       (rast_done),
        .frame_done      (frame_done),
        .tri_count       (tri_count),
        .frame_tri_count (frame_tri_count),
        .stall           (stall),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Rasterizer model: busy for RAST_CYC cycles, then a done pulse
    initial begin
        rast_busy = 1'b0;
        rast_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rast_done = 1'b0;
            if (!rst_n) begin
                rast_busy = 1'b0;
            end else if (rast_busy) begin
                r_rcnt--;
                if (r_rcnt == 0) begin
                    rast_busy = 1'b0;
                    rast_done = 1'b1;
                end
            end else if (rast_start) begin
                rast_busy = 1'b1;
                r_rcnt = RAST_CYC;
            end
        end
    end

    always @(negedge clk) begin
        if (dequeue && rast_busy) deq_busy++;
        if (rast_start) begin
            n_starts++;
            if (sb_q.size() == 0) check("start_unexp", 1, 0);
            else check("tri_id", tri_data, sb_q.pop_front());
        end
        if (frame_done) begin
            n_frames++;
            if (fq.size() == 0) begin
                check("frame_unexp", 1, 0);
            end else begin
                check("frame_tri_count", frame_tri_count, fq.pop_front());
                check("tri_count_clr", tri_count, 0);
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state_dbg != s && n < 200) begin
            tick();
            n++;
        end
        check(tag, state_dbg, s);
    endtask

    task automatic drive_ready();
        tri_id++;
        tri_data  = tri_id;
        tri_ready = 1'b1;
        sb_q.push_back(tri_id);
        tick();
        tri_ready = 1'b0;
    endtask

    task automatic gather_tri(input int dly);
        wait_state(3'd1, "wait_req");
        repeat (dly - 1) tick();
        drive_ready();
        check("start_lat", rast_start, 1'b1);
        check("deq_drop", dequeue, 1'b0);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!frame_done && n < 200) begin
            tick();
            n++;
        end
        check("frame_seen", frame_done, 1'b1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        en = 1'b0;
        tri_ready = 1'b0;
        tri_flush = 1'b0;
        repeat (3) tick();
        check("rst_deq", dequeue, 0);
        check("rst_start", rast_start, 0);
        check("rst_fd", frame_done, 0);
        check("rst_cnt", tri_count, 0);
        check("rst_stall", stall, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        // frame 1: three triangles, then flush while requesting
        repeat (3) gather_tri(4);
        wait_state(3'd1, "req_after3");
        check("tri_count3", tri_count, 3);
        tri_flush = 1'b1;
        fq.push_back(3);
        tick();
        tri_flush = 1'b0;
        check("flush_deq", dequeue, 0);
        check("flush_drain", state_dbg, 4);
        wait_frame();

        // stall timing from REQ entry
        wait_state(3'd1, "stall_req");
        k = 0;
        while (!stall && k < LIMIT + 10) begin
            tick();
            k++;
        end
        check("stall_lat", k, LIMIT);
        drive_ready();
        check("stall_clr", stall, 0);
        check("stall_start", rast_start, 1);

        // en drops while the gatherer is already producing a triangle
        wait_state(3'd1, "en_req");
        en = 1'b0;
        tick();
        check("en_idle", state_dbg, 0);
        drive_ready();
        check("late_start", state_dbg, 2);
        check("late_rs", rast_start, 1);
        wait_state(3'd0, "en_back_idle");
        en = 1'b1;
        gather_tri(4);

        // flush together with rast_done
        gather_tri(4);
        k = 0;
        while (!rast_done && k < 100) begin
            tick();
            k++;
        end
        tri_flush = 1'b1;
        fq.push_back(4);
        tick();
        tri_flush = 1'b0;
        check("fd_drain", state_dbg, 4);
        check("fd_cnt", tri_count, 4);
        wait_frame();

        // reset in RUN
        gather_tri(4);
        tick();
        tick();
        check("run_state", state_dbg, 3);
        rst_n = 1'b0;
        #1;
        check("arst_deq", dequeue, 0);
        check("arst_rs", rast_start, 0);
        check("arst_fd", frame_done, 0);
        check("arst_cnt", tri_count, 0);
        check("arst_ftc", frame_tri_count, 0);
        check("arst_stall", stall, 0);
        check("arst_state", state_dbg, 0);
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_state", state_dbg, 0);

        check("frames", n_frames, 2);
        check("starts", n_starts, tri_id);
        check("sb_left", sb_q.size(), 0);
        check("fq_left", fq.size(), 0);
        check("deq_busy", deq_busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
